// File: rtl/scan_pkg.sv
// Shared definitions for the multiplexer scan sequencer: state encoding,
// channel geometry and dwell counter width.
package scan_pkg;

  localparam int NUM_CHAN = 8;
  localparam int CHAN_W   = 3;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_next_chan.sv
// Round-robin channel picker: lowest enabled channel at or after ptr,
// wrapping 7 -> 0. Purely combinational.
module rr_next_chan
  import scan_pkg::*;
(
  input  logic [NUM_CHAN-1:0] mask,
  input  logic [CHAN_W-1:0]   ptr,
  output logic [CHAN_W-1:0]   next,
  output logic                found
);

  // Walk offsets from farthest to nearest so the nearest enabled channel wins.
  always_comb begin
    next  = '0;
    found = 1'b0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (mask[ptr + CHAN_W'(i)]) begin
        next  = ptr + CHAN_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans the channels of an external 8:1 byte multiplexer. Each selected
// channel is held for DWELL cycles to let the mux output settle, then the
// byte is captured and offered downstream with a valid/ready handshake.
module mux_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] mask,
  input  logic [7:0] mux_o,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic [7:0] data_out,
  output logic [2:0] chan_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  state_t            state, state_nx;
  logic [CHAN_W-1:0] ptr, sel, search_ptr, nxt_chan;
  logic [CNT_W-1:0]  cnt;
  logic              found;
  logic              load, capture, accept;

  // When a sample is being accepted the search must start just past the
  // channel being handed off, in the same edge that ptr is updated.
  assign search_ptr = (state == ST_OUT) ? chan_out + CHAN_W'(1) : ptr;

  rr_next_chan u_rr (
    .mask  (mask),
    .ptr   (search_ptr),
    .next  (nxt_chan),
    .found (found)
  );

  assign {x, y, z} = sel;
  assign busy      = (state != ST_IDLE);

  // Next-state and per-edge control strobes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    capture  = 1'b0;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && found) begin
          load     = 1'b1;
          state_nx = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = ST_OUT;
        end
      end
      ST_OUT: begin
        if (ready) begin
          accept = 1'b1;
          if (en && found) begin
            load     = 1'b1;
            state_nx = ST_DWELL;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Select, dwell counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
      cnt <= '0;
      ptr <= '0;
    end else begin
      if (accept) ptr <= chan_out + CHAN_W'(1);
      if (load) begin
        sel <= nxt_chan;
        cnt <= CNT_LOAD;
      end else if (state == ST_DWELL && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Captured sample and its qualifier; held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= 8'h00;
      chan_out <= '0;
      valid    <= 1'b0;
    end else if (capture) begin
      data_out <= mux_o;
      chan_out <= sel;
      valid    <= 1'b1;
    end else if (accept) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a behavioural multiplexer8
// whose inputs are AA,BA,BB,CB,CC,DC,DD,FF.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, ready;
  logic [7:0] mask, mux_o, data_out;
  logic       x, y, z, valid, busy;
  logic [2:0] chan_out;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer #(.DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mask(mask), .mux_o(mux_o),
    .x(x), .y(y), .z(z), .data_out(data_out), .chan_out(chan_out),
    .valid(valid), .ready(ready), .busy(busy)
  );

  // multiplexer8 model
  always_comb begin
    case ({x, y, z})
      3'd0: mux_o = 8'hAA;
      3'd1: mux_o = 8'hBA;
      3'd2: mux_o = 8'hBB;
      3'd3: mux_o = 8'hCB;
      3'd4: mux_o = 8'hCC;
      3'd5: mux_o = 8'hDC;
      3'd6: mux_o = 8'hDD;
      default: mux_o = 8'hFF;
    endcase
  end

  function automatic logic [7:0] exp_data(input int ch);
    case (ch)
      0: return 8'hAA;
      1: return 8'hBA;
      2: return 8'hBB;
      3: return 8'hCB;
      4: return 8'hCC;
      5: return 8'hDC;
      6: return 8'hDD;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  {24'd0, data_out}, 32'h00);
    chk({tag, "_chan"},  {29'd0, chan_out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid},    32'd0);
    chk({tag, "_busy"},  {31'd0, busy},     32'd0);
    chk({tag, "_sel"},   {29'd0, x, y, z},  32'd0);
  endtask

  // One sample slot: the first edge loads sel, the next three dwell with sel
  // held (four cycles of stable select), the fifth edge captures.
  task automatic expect_sample(input string tag, input int ch);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk({tag, "_dwell_valid"}, {31'd0, valid}, 32'd0);
      chk({tag, "_dwell_sel"},   {29'd0, x, y, z}, ch);
      chk({tag, "_dwell_busy"},  {31'd0, busy}, 32'd1);
    end
    tick();
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    chk({tag, "_chan"},  {29'd0, chan_out}, ch);
    chk({tag, "_data"},  {24'd0, data_out}, exp_data(ch));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mask = 8'h00; ready = 1'b0;

    // reset state
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("post_reset_idle");

    // full mask, free-running downstream: 0..7 then wrap to 0
    en = 1'b1; mask = 8'hFF; ready = 1'b1;
    for (int i = 0; i < 9; i++) expect_sample("scan_ff", i % 8);

    // two channels enabled: 1 and 4 alternate
    mask = 8'b0001_0010;
    expect_sample("mask12_a", 1);
    expect_sample("mask12_b", 4);
    expect_sample("mask12_c", 1);

    // downstream stall: everything holds for 10 cycles
    ready = 1'b0; mask = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_chan",  {29'd0, chan_out}, 32'd1);
      chk("stall_data",  {24'd0, data_out}, 32'hBA);
      chk("stall_sel",   {29'd0, x, y, z}, 32'd1);
    end
    ready = 1'b1;
    expect_sample("after_stall", 2);

    // en dropped mid-dwell on channel 3: sample still delivered
    tick();
    chk("en_drop_load_sel", {29'd0, x, y, z}, 32'd3);
    tick();
    en = 1'b0;
    tick(); tick(); tick();
    chk("en_drop_valid", {31'd0, valid}, 32'd1);
    chk("en_drop_chan",  {29'd0, chan_out}, 32'd3);
    chk("en_drop_data",  {24'd0, data_out}, 32'hCB);
    tick();
    chk("en_drop_busy",  {31'd0, busy},  32'd0);
    chk("en_drop_vclr",  {31'd0, valid}, 32'd0);
    chk("en_drop_sel",   {29'd0, x, y, z}, 32'd3);
    tick();
    chk("idle_hold_busy", {31'd0, busy}, 32'd0);
    chk("idle_hold_sel",  {29'd0, x, y, z}, 32'd3);

    // resume from ptr=4, then reset in the middle of channel 6's dwell
    en = 1'b1;
    expect_sample("resume_4", 4);
    expect_sample("resume_5", 5);
    tick();
    chk("pre_rst_sel", {29'd0, x, y, z}, 32'd6);
    tick();
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    tick();
    chk_zero("rst_held");
    rst = 1'b0;
    expect_sample("after_rst", 0);

    // empty mask: stays idle; then only channel 7
    mask = 8'h00;
    tick();
    chk("mask0_busy",  {31'd0, busy},  32'd0);
    chk("mask0_valid", {31'd0, valid}, 32'd0);
    tick(); tick();
    chk("mask0_still_busy", {31'd0, busy}, 32'd0);
    chk("mask0_still_valid", {31'd0, valid}, 32'd0);
    mask = 8'h80;
    expect_sample("mask80_a", 7);
    expect_sample("mask80_b", 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
